placement_readback: RTL and testbench
=====================================

// Module: placement_readback
// PURPOSE
//  Read-side companion to the placement engine: after placement finishes, walks every node id,
//  reads its X/Y from the pos_X/pos_Y RAMs, cross-checks grid[x*N+y]==id, streams one record per
//  node over a valid/ready port, and counts inconsistencies. Sits beside the placer on the same
//  pos/grid RAM read ports; placer must be idle (not writing) while this block is busy.
// PARAMETERS
//  N        9    grid side; legal coordinates 0..N-1
//  N_NODES  128  node ids walked, 0..N_NODES-1 (2**pos RAM depth, 7 bits)
//  POS_AW   7    pos RAM address width
//  GRID_AW  12   grid RAM address width
//  W        32   data width of all RAMs and record fields (signed)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  start      in   1        1-cycle pulse; ignored unless state==IDLE or DONE
//  rd_pos     out  1        read strobe to pos_X and pos_Y (shared)
//  addr_pos   out  POS_AW   node id to pos_X/pos_Y
//  dout_px    in   W        pos_X read data (signed; -1 = unplaced)
//  dout_py    in   W        pos_Y read data (signed; -1 = unplaced)
//  rd_grid    out  1        read strobe to grid RAM
//  addr_grid  out  GRID_AW  x*N+y
//  dout_grid  in   W        grid read data (node id, -1 = empty)
//  rec_valid  out  1        record available
//  rec_ready  in   1        consumer accepts record
//  rec_node   out  W        node id
//  rec_x      out  W        X read back
//  rec_y      out  W        Y read back
//  rec_flags  out  2        [0]=placed, [1]=error
//  busy       out  1        high from start accept until DONE
//  done       out  1        level, high in DONE until next start or reset
//  err_count  out  W        errors in current/last pass (saturates at 2**W-1)
// BEHAVIOUR
//  - Reset (async): state=IDLE; every output 0 (rec_* fields 0, err_count 0); id counter 0.
//  - RAM timing: strobes/addresses registered; RAM captures on the edge where strobe high;
//    data sampled one wait cycle later (issue, WAIT, use) = 2 cycles per read.
//  - FSM: IDLE -start-> RD_POS (id<=0, err_count<=0, busy<=1)
//    RD_POS: rd_pos=1, addr_pos=id -> WAIT_POS -> CHK
//    CHK: latch x,y. x==-1 or y==-1 -> placed=0, error=(x!=y) -> EMIT
//         x or y outside [0,N-1] -> placed=1, error=1, no grid read -> EMIT
//         else addr_grid=x*N+y (low GRID_AW bits), rd_grid=1 -> WAIT_GRID -> GCHK
//    GCHK: placed=1, error=(dout_grid!=id) -> EMIT
//    EMIT: rec_valid=1, fields stable until rec_valid&rec_ready at an edge; on that edge
//          rec_valid<=0, err_count+=error, id+=1; id==N_NODES-1 -> DONE else RD_POS
//    DONE: busy=0, done=1; start -> RD_POS (new pass, done<=0, err_count<=0)
//  - Min throughput: 7 cycles/record with rec_ready tied high; total 7*N_NODES+1 cycles.
//  - rec_ready held low stalls indefinitely in EMIT; no RAM reads issued while stalled.
//  - start while busy: ignored, no effect on pass. Reset mid-pass: immediate IDLE, all cleared.
//  - Only read strobes driven; never writes any RAM. Coordinate compare is signed.
// TESTING
//  1 Fixed RAM image, N=9: node 3 at (2,5), grid[23]=3, ready=1 -> record {3,2,5,placed=1,err=0}.
//  2 All pos=-1, start -> 128 records placed=0,err=0; done at cycle 7*128+1; err_count=0.
//  3 grid[23]=7 for node 3 at (2,5) -> rec_flags=2'b11, final err_count=1.
//  4 pos_X[4]=9 (out of range) -> error=1, rd_grid never asserted for node 4.
//  5 rec_ready low 20 cycles in EMIT -> rec_* unchanged, rd_pos/rd_grid low throughout.
//  6 reset asserted mid-pass (node 50) -> outputs 0 asynchronously; new start restarts at node 0.

Source files
------------

// File: rtl/placement_readback.sv
// Post-placement readback: walks every node id, reads its X/Y and the grid cell it claims,
// streams one record per node over valid/ready and counts inconsistent entries.
module placement_readback #(
    parameter int unsigned N       = 9,
    parameter int unsigned N_NODES = 128,
    parameter int unsigned POS_AW  = 7,
    parameter int unsigned GRID_AW = 12,
    parameter int unsigned W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    output logic                o_rd_pos,
    output logic [POS_AW-1:0]   o_addr_pos,
    input  logic signed [W-1:0] i_dout_px,
    input  logic signed [W-1:0] i_dout_py,
    output logic                o_rd_grid,
    output logic [GRID_AW-1:0]  o_addr_grid,
    input  logic signed [W-1:0] i_dout_grid,
    output logic                o_rec_valid,
    input  logic                i_rec_ready,
    output logic [W-1:0]        o_rec_node,
    output logic [W-1:0]        o_rec_x,
    output logic [W-1:0]        o_rec_y,
    output logic [1:0]          o_rec_flags,
    output logic                o_busy,
    output logic                o_done,
    output logic [W-1:0]        o_err_count
);

    localparam logic signed [W-1:0] LastCoord = W'(N - 1);
    localparam logic [POS_AW-1:0]   LastId    = POS_AW'(N_NODES - 1);
    localparam logic [GRID_AW-1:0]  GridN     = GRID_AW'(N);

    typedef enum logic [3:0] {
        StIdle,
        StRdPos,
        StWaitPos,
        StChk,
        StRdGrid,
        StWaitGrid,
        StGChk,
        StEmit,
        StDone
    } state_t;

    state_t              r_state;
    logic [POS_AW-1:0]   r_id;
    logic                r_need_grid;
    logic                r_rd_pos;
    logic [POS_AW-1:0]   r_addr_pos;
    logic                r_rd_grid;
    logic [GRID_AW-1:0]  r_addr_grid;
    logic                r_rec_valid;
    logic [W-1:0]        r_rec_node;
    logic [W-1:0]        r_rec_x;
    logic [W-1:0]        r_rec_y;
    logic [1:0]          r_rec_flags;
    logic                r_busy;
    logic                r_done;
    logic [W-1:0]        r_err_count;

    logic                w_x_unplaced;
    logic                w_y_unplaced;
    logic                w_x_in_range;
    logic                w_y_in_range;
    logic [GRID_AW-1:0]  w_grid_addr;
    logic [W-1:0]        w_id_ext;
    logic                w_grid_err;

    assign w_x_unplaced = (i_dout_px == {W{1'b1}});
    assign w_y_unplaced = (i_dout_py == {W{1'b1}});
    assign w_x_in_range = !i_dout_px[W-1] && (i_dout_px <= LastCoord);
    assign w_y_in_range = !i_dout_py[W-1] && (i_dout_py <= LastCoord);
    // Only meaningful when both coordinates are in range, so the low bits suffice.
    assign w_grid_addr  = i_dout_px[GRID_AW-1:0] * GridN + i_dout_py[GRID_AW-1:0];
    assign w_id_ext     = {{(W - POS_AW){1'b0}}, r_id};
    assign w_grid_err   = ($unsigned(i_dout_grid) != w_id_ext);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_id        <= '0;
            r_need_grid <= 1'b0;
            r_rd_pos    <= 1'b0;
            r_addr_pos  <= '0;
            r_rd_grid   <= 1'b0;
            r_addr_grid <= '0;
            r_rec_valid <= 1'b0;
            r_rec_node  <= '0;
            r_rec_x     <= '0;
            r_rec_y     <= '0;
            r_rec_flags <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state     <= StRdPos;
                        r_id        <= '0;
                        r_err_count <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_rd_pos    <= 1'b1;
                        r_addr_pos  <= '0;
                    end
                end
                StRdPos: begin
                    r_rd_pos <= 1'b0;
                    r_state  <= StWaitPos;
                end
                StWaitPos: r_state <= StChk;
                StChk: begin
                    r_rec_node <= w_id_ext;
                    r_rec_x    <= i_dout_px;
                    r_rec_y    <= i_dout_py;
                    if (w_x_unplaced || w_y_unplaced) begin
                        r_rec_flags <= {(i_dout_px != i_dout_py), 1'b0};
                        r_need_grid <= 1'b0;
                    end else if (!(w_x_in_range && w_y_in_range)) begin
                        r_rec_flags <= 2'b11;
                        r_need_grid <= 1'b0;
                    end else begin
                        r_rec_flags <= 2'b00;
                        r_need_grid <= 1'b1;
                        r_rd_grid   <= 1'b1;
                        r_addr_grid <= w_grid_addr;
                    end
                    // Grid stages are walked even without a read to keep a fixed 7-cycle cadence.
                    r_state <= StRdGrid;
                end
                StRdGrid: begin
                    r_rd_grid <= 1'b0;
                    r_state   <= StWaitGrid;
                end
                StWaitGrid: r_state <= StGChk;
                StGChk: begin
                    if (r_need_grid) begin
                        r_rec_flags <= {w_grid_err, 1'b1};
                    end
                    r_rec_valid <= 1'b1;
                    r_state     <= StEmit;
                end
                StEmit: begin
                    if (i_rec_ready) begin
                        r_rec_valid <= 1'b0;
                        if (r_rec_flags[1] && (r_err_count != {W{1'b1}})) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        r_id <= r_id + 1'b1;
                        if (r_id == LastId) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_rd_pos   <= 1'b1;
                            r_addr_pos <= r_id + 1'b1;
                            r_state    <= StRdPos;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_rd_pos    = r_rd_pos;
    assign o_addr_pos  = r_addr_pos;
    assign o_rd_grid   = r_rd_grid;
    assign o_addr_grid = r_addr_grid;
    assign o_rec_valid = r_rec_valid;
    assign o_rec_node  = r_rec_node;
    assign o_rec_x     = r_rec_x;
    assign o_rec_y     = r_rec_y;
    assign o_rec_flags = r_rec_flags;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_placement_readback.sv
// Directed bench for placement_readback: behavioural pos/grid RAMs and hand-computed records.
module tb_placement_readback;

    localparam int NN = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rec_ready = 1'b0;
    logic        rd_pos;
    logic [6:0]  addr_pos;
    logic [31:0] dout_px = '0;
    logic [31:0] dout_py = '0;
    logic        rd_grid;
    logic [11:0] addr_grid;
    logic [31:0] dout_grid = '0;
    logic        rec_valid;
    logic [31:0] rec_node;
    logic [31:0] rec_x;
    logic [31:0] rec_y;
    logic [1:0]  rec_flags;
    logic        busy;
    logic        done;
    logic [31:0] err_count;

    logic [31:0] mem_x [NN];
    logic [31:0] mem_y [NN];
    logic [31:0] mem_g [4096];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int grid_reads = 0;
    int node4_reads = 0;

    placement_readback dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (start),
        .o_rd_pos    (rd_pos),
        .o_addr_pos  (addr_pos),
        .i_dout_px   (dout_px),
        .i_dout_py   (dout_py),
        .o_rd_grid   (rd_grid),
        .o_addr_grid (addr_grid),
        .i_dout_grid (dout_grid),
        .o_rec_valid (rec_valid),
        .i_rec_ready (rec_ready),
        .o_rec_node  (rec_node),
        .o_rec_x     (rec_x),
        .o_rec_y     (rec_y),
        .o_rec_flags (rec_flags),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_count (err_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs: data appears after the strobe edge and holds until the next read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_pos) begin
            dout_px <= mem_x[addr_pos];
            dout_py <= mem_y[addr_pos];
        end
        if (rd_grid) begin
            dout_grid  <= mem_g[addr_grid];
            grid_reads <= grid_reads + 1;
            if (rec_node == 32'd4) node4_reads <= node4_reads + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(output int scyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        scyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a record (ready assumed high), checks it, then lets the accepting edge pass.
    task automatic expect_rec(input int node, input logic [31:0] ex, input logic [31:0] ey,
                              input logic [1:0] ef);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rec_valid) found = 1'b1;
        end
        chk($sformatf("rec_timeout[%0d]", node), 64'(found), 64'd1);
        if (found) begin
            chk($sformatf("rec_node[%0d]", node), 64'(rec_node), 64'(node));
            chk($sformatf("rec_x[%0d]", node), 64'(rec_x), 64'(ex));
            chk($sformatf("rec_y[%0d]", node), 64'(rec_y), 64'(ey));
            chk($sformatf("rec_flags[%0d]", node), 64'(rec_flags), 64'(ef));
            @(posedge clk);
        end
    endtask

    task automatic wait_done(output int dcyc);
        bit found = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                dcyc  = cyc;
            end
        end
        chk("done_timeout", 64'(found), 64'd1);
    endtask

    logic [31:0] ex1 [8] = '{32'd0, -32'sd1, 32'd8, 32'd2, 32'd9, -32'sd1, 32'd1, 32'd0};
    logic [31:0] ey1 [8] = '{32'd0, -32'sd1, 32'd8, 32'd5, 32'd0, 32'd2, 32'd1, -32'sd3};
    logic [1:0]  ef1 [8] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};

    initial begin
        int scyc;
        int dcyc;
        int gr0;
        int n40;
        bit found;

        for (int i = 0; i < NN; i++) begin
            mem_x[i] = '1;
            mem_y[i] = '1;
        end
        for (int i = 0; i < 4096; i++) mem_g[i] = '1;

        // Reset state
        #2 reset = 1'b1;
        #1;
        chk("rst_strobes", 64'({rd_pos, rd_grid, rec_valid, busy, done}), 64'd0);
        chk("rst_addr", 64'({addr_pos, addr_grid}), 64'd0);
        chk("rst_rec", 64'({rec_node, rec_x}), 64'd0);
        chk("rst_rec2", 64'({rec_y, rec_flags}), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rec_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 64'({busy, rd_pos}), 64'd0);

        // All nodes unplaced: 128 clean records, fixed cadence, no grid reads
        gr0 = grid_reads;
        pulse_start(scyc);
        chk("t2_busy", 64'({busy, done}), 64'b10);
        chk("t2_first_rd", 64'({rd_pos, addr_pos}), {56'd0, 1'b1, 7'd0});
        for (int i = 0; i < NN; i++) expect_rec(i, '1, '1, 2'b00);
        wait_done(dcyc);
        chk("t2_done_cycle", 64'(dcyc - scyc + 1), 64'(7 * NN + 1));
        chk("t2_err_count", 64'(err_count), 64'd0);
        chk("t2_busy_end", 64'({busy, done}), 64'b01);
        chk("t2_grid_reads", 64'(grid_reads - gr0), 64'd0);

        // Mixed image: placed, corner, out-of-range, half-unplaced, empty cell, negative y
        mem_x[0] = 0;  mem_y[0] = 0;  mem_g[0] = 0;
        mem_x[2] = 8;  mem_y[2] = 8;  mem_g[80] = 2;
        mem_x[3] = 2;  mem_y[3] = 5;  mem_g[23] = 3;
        mem_x[4] = 9;  mem_y[4] = 0;
        mem_x[5] = '1; mem_y[5] = 2;
        mem_x[6] = 1;  mem_y[6] = 1;
        mem_x[7] = 0;  mem_y[7] = -3;
        gr0 = grid_reads;
        n40 = node4_reads;
        pulse_start(scyc);
        for (int i = 0; i < 8; i++) expect_rec(i, ex1[i], ey1[i], ef1[i]);
        wait_done(dcyc);
        chk("t1_err_count", 64'(err_count), 64'd4);
        chk("t1_grid_reads", 64'(grid_reads - gr0), 64'd4);
        chk("t4_node4_no_grid", 64'(node4_reads - n40), 64'd0);

        // Grid disagrees for node 3; other faults removed
        mem_g[23] = 7;
        for (int i = 4; i < 8; i++) begin
            mem_x[i] = '1;
            mem_y[i] = '1;
        end
        pulse_start(scyc);
        chk("t3_restart_clears", 64'({done, err_count}), 64'd0);
        expect_rec(0, 32'd0, 32'd0, 2'b01);
        expect_rec(1, '1, '1, 2'b00);
        expect_rec(2, 32'd8, 32'd8, 2'b01);
        expect_rec(3, 32'd2, 32'd5, 2'b11);
        wait_done(dcyc);
        chk("t3_err_count", 64'(err_count), 64'd1);

        // Back-pressure: 20 stalled cycles on node 0
        rec_ready = 1'b0;
        pulse_start(scyc);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rec_valid) found = 1'b1;
        end
        chk("t5_valid_timeout", 64'(found), 64'd1);
        for (int k = 0; k < 20; k++) begin
            chk("t5_stall_node", 64'({rec_valid, rec_node}), {31'd0, 1'b1, 32'd0});
            chk("t5_stall_xy", {rec_x, rec_y}, 64'd0);
            chk("t5_stall_rd", 64'({rd_pos, rd_grid, rec_flags}), 64'b0001);
            @(negedge clk);
        end
        rec_ready = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) expect_rec(i, 32'd2, 32'd5, 2'b11);
            else if (i == 2) expect_rec(i, 32'd8, 32'd8, 2'b01);
            else expect_rec(i, '1, '1, 2'b00);
        end

        // Start while busy is ignored
        pulse_start(scyc);
        chk("t6_busy_kept", 64'({busy, done}), 64'b10);
        for (int i = 21; i < 50; i++) expect_rec(i, '1, '1, 2'b00);

        // Asynchronous reset while node 50 is presented
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rec_valid) found = 1'b1;
        end
        chk("t6_node50_timeout", 64'(found), 64'd1);
        chk("t6_node50", 64'(rec_node), 64'd50);
        chk("t6_err_before", 64'(err_count), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_strobes", 64'({rd_pos, rd_grid, rec_valid, busy, done}), 64'd0);
        chk("t6_rst_rec", 64'({rec_node, err_count}), 64'd0);
        chk("t6_rst_addr", 64'({addr_pos, addr_grid, rec_flags}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_after", 64'({busy, rd_pos, rec_valid}), 64'd0);
        pulse_start(scyc);
        chk("t6_restart_rd", 64'({rd_pos, addr_pos}), {56'd0, 1'b1, 7'd0});
        expect_rec(0, 32'd0, 32'd0, 2'b01);
        expect_rec(1, '1, '1, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
